// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for gate-level response checkers.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions of each gate inside expected/observed/mismatch vectors.
  localparam int MB_NOT  = 0;
  localparam int MB_AND  = 1;
  localparam int MB_NAND = 2;
  localparam int MB_OR   = 3;
  localparam int MB_NOR  = 4;
  localparam int MB_XOR  = 5;
  localparam int MB_XNOR = 6;
  localparam int NUM_GATES = 7;

  // Golden truth table for the two-input gate block; not is defined on a.
  function automatic logic [NUM_GATES-1:0] exp_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e          = '0;
    e[MB_NOT]  = ~a;
    e[MB_AND]  = a & b;
    e[MB_NAND] = ~(a & b);
    e[MB_OR]   = a | b;
    e[MB_NOR]  = ~(a | b);
    e[MB_XOR]  = a ^ b;
    e[MB_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the two-input gate block: builds the expected
// output vector from a/b and flags every gate whose observed value differs.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  input  logic [NUM_GATES-1:0] obs,
  output logic [NUM_GATES-1:0] mask
);

  assign mask = obs ^ exp_gates(a, b);

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for the two-input gate block. Counts samples and
// mismatching samples, records which {b,a} combinations were exercised,
// captures the first failing sample and reports done/pass at end of run.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | sampling on in_valid until NUM_VECTORS samples are registered
//   DONE  | results frozen, waiting for start to re-run
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             not_g,
  input  logic             and_g,
  input  logic             nand_g,
  input  logic             or_g,
  input  logic             nor_g,
  input  logic             xor_g,
  input  logic             xnor_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic             ff_valid,
  output logic [1:0]       ff_vec,
  output logic [6:0]       ff_mask
);

  // Run length is tracked separately from the saturating vec_count so a run
  // still terminates when NUM_VECTORS exceeds the counter range.
  localparam int RUN_W = (NUM_VECTORS < 2) ? 1 : $clog2(NUM_VECTORS + 1);
  localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e                 state_q, state_d;
  logic [RUN_W-1:0]       remain_q;
  logic [NUM_GATES-1:0]   obs;
  logic [NUM_GATES-1:0]   mask;
  logic                   start_run;
  logic                   take;
  logic                   finish;
  logic                   sample_bad;
  logic [CNT_W-1:0]       vec_next;
  logic [CNT_W-1:0]       err_next;
  logic [3:0]             cov_next;

  assign obs = {xnor_g, xor_g, nor_g, or_g, nand_g, and_g, not_g};

  gate_ref_model u_ref (
    .a    (a),
    .b    (b),
    .obs  (obs),
    .mask (mask)
  );

  assign sample_bad = (mask != '0);
  assign vec_next   = (vec_count == CNT_MAX) ? vec_count : vec_count + CNT_W'(1);
  assign err_next   = (sample_bad && (err_count != CNT_MAX)) ? err_count + CNT_W'(1)
                                                            : err_count;
  assign cov_next   = cov | (4'b0001 << {b, a});

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the per-edge control strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    take      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          take = 1'b1;
          if (remain_q == RUN_W'(1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result datapath: clears on run start, accumulates on each taken sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_q  <= '0;
      vec_count <= '0;
      err_count <= '0;
      cov       <= '0;
      ff_valid  <= 1'b0;
      ff_vec    <= '0;
      ff_mask   <= '0;
      pass      <= 1'b0;
    end else if (start_run) begin
      remain_q  <= RUN_LOAD;
      vec_count <= '0;
      err_count <= '0;
      cov       <= '0;
      ff_valid  <= 1'b0;
      ff_vec    <= '0;
      ff_mask   <= '0;
      pass      <= 1'b0;
    end else if (take) begin
      remain_q  <= remain_q - RUN_W'(1);
      vec_count <= vec_next;
      err_count <= err_next;
      cov       <= cov_next;
      if (sample_bad && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_vec   <= {b, a};
        ff_mask  <= mask;
      end
      if (finish) pass <= (err_next == '0) && (cov_next == 4'hF);
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Self-checking bench for gate_resp_checker: table-driven directed runs,
// hand sequences for reset/restart corners, a narrow-counter instance, and
// random stimulus against a behavioural model.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0;
  logic not_g = 1'b0, and_g = 1'b0, nand_g = 1'b0, or_g = 1'b0;
  logic nor_g = 1'b0, xor_g = 1'b0, xnor_g = 1'b0;

  logic       busy0, done0, pass0, ffv0;
  logic [7:0] vec0, err0;
  logic [3:0] cov0;
  logic [1:0] ffvec0;
  logic [6:0] ffm0;

  logic       busy1, done1, pass1, ffv1;
  logic [1:0] vec1, err1;
  logic [3:0] cov1;
  logic [1:0] ffvec1;
  logic [6:0] ffm1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_resp_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .a(a), .b(b),
    .not_g(not_g), .and_g(and_g), .nand_g(nand_g), .or_g(or_g), .nor_g(nor_g),
    .xor_g(xor_g), .xnor_g(xnor_g),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vec0), .err_count(err0),
    .cov(cov0), .ff_valid(ffv0), .ff_vec(ffvec0), .ff_mask(ffm0)
  );

  gate_resp_checker #(.NUM_VECTORS(6), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .a(a), .b(b),
    .not_g(not_g), .and_g(and_g), .nand_g(nand_g), .or_g(or_g), .nor_g(nor_g),
    .xor_g(xor_g), .xnor_g(xnor_g),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vec1), .err_count(err1),
    .cov(cov1), .ff_valid(ffv1), .ff_vec(ffvec1), .ff_mask(ffm1)
  );

  // Behavioural model of dut0 (NUM_VECTORS=4, counters saturate at 255).
  bit         m_running, m_done, m_pass, m_ffv;
  int         m_taken, m_vec, m_err;
  logic [3:0] m_cov;
  logic [1:0] m_ffvec;
  logic [6:0] m_ffm;

  function automatic logic [6:0] ref_gates(input int x, input int y);
    int an, o, xr;
    an = x * y;
    o  = (x + y > 0) ? 1 : 0;
    xr = (x + y) % 2;
    return {1'(1 - xr), 1'(xr), 1'(1 - o), 1'(o), 1'(1 - an), 1'(an), 1'(1 - x)};
  endfunction

  task automatic model_reset();
    m_running = 0; m_done = 0; m_pass = 0; m_ffv = 0;
    m_taken = 0; m_vec = 0; m_err = 0;
    m_cov = '0; m_ffvec = '0; m_ffm = '0;
  endtask

  task automatic model_step(input logic st, input logic v, input int x, input int y,
                            input logic [6:0] o);
    logic [6:0] mm;
    mm = o ^ ref_gates(x, y);
    if (!m_running) begin
      if (st) begin
        model_reset();
        m_running = 1;
      end
    end else if (v) begin
      m_taken++;
      m_vec = (m_vec < 255) ? m_vec + 1 : 255;
      m_cov[y * 2 + x] = 1'b1;
      if (mm != 0) begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
        if (!m_ffv) begin
          m_ffv = 1; m_ffvec = 2'(y * 2 + x); m_ffm = mm;
        end
      end
      if (m_taken == 4) begin
        m_running = 0;
        m_done    = 1;
        m_pass    = (m_err == 0) && (m_cov == 4'hF);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".busy"},    busy0,  m_running);
    chk({tag, ".done"},    done0,  m_done);
    chk({tag, ".pass"},    pass0,  m_pass);
    chk({tag, ".vec"},     vec0,   m_vec);
    chk({tag, ".err"},     err0,   m_err);
    chk({tag, ".cov"},     cov0,   m_cov);
    chk({tag, ".ffv"},     ffv0,   m_ffv);
    chk({tag, ".ffvec"},   ffvec0, m_ffvec);
    chk({tag, ".ffmask"},  ffm0,   m_ffm);
  endtask

  // One clock: drive at the negedge, model on the posedge, return at negedge.
  task automatic cyc(input logic s0, input logic s1, input logic v, input logic aa,
                     input logic bb, input logic [6:0] fl);
    logic [6:0] o;
    o = ref_gates(int'(aa), int'(bb)) ^ fl;
    start0 = s0; start1 = s1; in_valid = v; a = aa; b = bb;
    {xnor_g, xor_g, nor_g, or_g, nand_g, and_g, not_g} = o;
    @(posedge clk);
    model_step(s0, v, int'(aa), int'(bb), o);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    cmp_model("reset");
    chk("reset.busy1", busy1, 0);
    chk("reset.done1", done1, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       st, v, a, b, xs;
    logic       bz, dn, ps;
    logic [7:0] vc, ec;
    logic [3:0] cv;
    logic       ffv;
    logic [1:0] ffvec;
    logic [6:0] ffm;
  } row_t;

  row_t tbl[15];

  function automatic row_t mk(logic st, logic v, logic aa, logic bb, logic xs,
                              logic bz, logic dn, logic ps, logic [7:0] vc,
                              logic [7:0] ec, logic [3:0] cv, logic ffv,
                              logic [1:0] ffvec, logic [6:0] ffm);
    row_t r;
    r.st = st; r.v = v; r.a = aa; r.b = bb; r.xs = xs;
    r.bz = bz; r.dn = dn; r.ps = ps; r.vc = vc; r.ec = ec; r.cv = cv;
    r.ffv = ffv; r.ffvec = ffvec; r.ffm = ffm;
    return r;
  endfunction

  initial begin
    logic [6:0] fl;
    logic       rs, rv, ra, rb;

    // good run 00,10,01,11 (a listed first)
    tbl[0]  = mk(1,0,0,0,0, 1,0,0, 0,0,4'h0, 0,2'b00,7'h00);
    tbl[1]  = mk(0,1,0,0,0, 1,0,0, 1,0,4'h1, 0,2'b00,7'h00);
    tbl[2]  = mk(0,1,1,0,0, 1,0,0, 2,0,4'h3, 0,2'b00,7'h00);
    tbl[3]  = mk(0,1,0,1,0, 1,0,0, 3,0,4'h7, 0,2'b00,7'h00);
    tbl[4]  = mk(0,1,1,1,0, 0,1,1, 4,0,4'hF, 0,2'b00,7'h00);
    // xor_g stuck at 0
    tbl[5]  = mk(1,0,0,0,1, 1,0,0, 0,0,4'h0, 0,2'b00,7'h00);
    tbl[6]  = mk(0,1,0,0,1, 1,0,0, 1,0,4'h1, 0,2'b00,7'h00);
    tbl[7]  = mk(0,1,1,0,1, 1,0,0, 2,1,4'h3, 1,2'b01,7'b0100000);
    tbl[8]  = mk(0,1,0,1,1, 1,0,0, 3,2,4'h7, 1,2'b01,7'b0100000);
    tbl[9]  = mk(0,1,1,1,1, 0,1,0, 4,2,4'hF, 1,2'b01,7'b0100000);
    // coverage hole: 00,00,11,11
    tbl[10] = mk(1,0,0,0,0, 1,0,0, 0,0,4'h0, 0,2'b00,7'h00);
    tbl[11] = mk(0,1,0,0,0, 1,0,0, 1,0,4'h1, 0,2'b00,7'h00);
    tbl[12] = mk(0,1,0,0,0, 1,0,0, 2,0,4'h1, 0,2'b00,7'h00);
    tbl[13] = mk(0,1,1,1,0, 1,0,0, 3,0,4'h9, 0,2'b00,7'h00);
    tbl[14] = mk(0,1,1,1,0, 0,1,0, 4,0,4'h9, 0,2'b00,7'h00);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      fl = '0;
      if (tbl[i].xs) fl[5] = ref_gates(int'(tbl[i].a), int'(tbl[i].b)) >> 5;
      cyc(tbl[i].st, 1'b0, tbl[i].v, tbl[i].a, tbl[i].b, fl);
      chk($sformatf("tbl%0d.busy", i),   busy0,  tbl[i].bz);
      chk($sformatf("tbl%0d.done", i),   done0,  tbl[i].dn);
      chk($sformatf("tbl%0d.pass", i),   pass0,  tbl[i].ps);
      chk($sformatf("tbl%0d.vec", i),    vec0,   tbl[i].vc);
      chk($sformatf("tbl%0d.err", i),    err0,   tbl[i].ec);
      chk($sformatf("tbl%0d.cov", i),    cov0,   tbl[i].cv);
      chk($sformatf("tbl%0d.ffv", i),    ffv0,   tbl[i].ffv);
      chk($sformatf("tbl%0d.ffvec", i),  ffvec0, tbl[i].ffvec);
      chk($sformatf("tbl%0d.ffmask", i), ffm0,   tbl[i].ffm);
    end

    // reset mid-run clears immediately, then a clean run passes
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 1, 1, 0, 7'h01);
    #2;
    do_reset();
    chk("midrst.vec_after", vec0, 0);
    chk("midrst.ffv_after", ffv0, 0);
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 1, 1, 0, '0);
    cyc(0, 0, 1, 0, 1, '0);
    cyc(0, 0, 1, 1, 1, '0);
    chk("rerun.pass", pass0, 1);
    chk("rerun.vec", vec0, 4);
    cmp_model("rerun");

    // start in RUN ignored; in_valid in DONE ignored; start+valid in DONE
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(1, 0, 1, 1, 0, '0);
    chk("runstart.vec", vec0, 2);
    chk("runstart.busy", busy0, 1);
    cyc(0, 0, 1, 0, 1, '0);
    cyc(0, 0, 1, 1, 1, 7'h08);
    cmp_model("runstart.end");
    cyc(0, 0, 1, 0, 0, 7'h7F);
    chk("donevalid.vec", vec0, 4);
    chk("donevalid.err", err0, 1);
    cmp_model("donevalid");
    cyc(1, 0, 1, 1, 1, 7'h7F);
    chk("restart.done", done0, 0);
    chk("restart.busy", busy0, 1);
    chk("restart.vec", vec0, 0);
    chk("restart.err", err0, 0);
    cmp_model("restart");

    // narrow counters, longer run, every sample failing
    do_reset();
    cyc(0, 1, 0, 0, 0, '0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 1, 1'(k), 1'(k >> 1), 7'h7F);
      chk($sformatf("sat%0d.err", k), err1, (k < 3) ? k : 3);
      chk($sformatf("sat%0d.vec", k), vec1, (k < 3) ? k : 3);
      chk($sformatf("sat%0d.done", k), done1, (k == 6) ? 1 : 0);
    end
    chk("sat.pass", pass1, 0);
    chk("sat.busy", busy1, 0);
    chk("sat.ffmask", ffm1, 7'h7F);
    chk("sat.ffvec", ffvec1, 2'b01);

    // random stimulus against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 3) != 0);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 5) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
      cyc(rs, 1'b0, rv, ra, rb, fl);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
